uart_tx_io: RTL and testbench

Memory-mapped 8N1 UART transmitter that lets a running program send bytes to a host over the board's `tx` pin. It is the outbound counterpart of the UART programmer path, which only receives. It sits behind `MemOrIO` on the CPU clock domain: the CPU's IO-write strobe pushes a byte into an internal FIFO, and a serializer drains the FIFO at the configured baud rate. A status word is returned for IO reads so software can poll before writing.

---
 rtl/uart_tx_io_pkg.sv | 22 ++
 rtl/uart_tx_io_byte_fifo.sv | 66 ++++++
 rtl/uart_tx_io.sv | 145 ++++++++++++++
 tb/tb_uart_tx_io.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_io_pkg.sv
// Shared definitions for the memory-mapped UART transmit path.
package uart_tx_io_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Bit positions inside the status word returned on IO reads.
   localparam int ST_BUSY  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_FULL  = 2;
   localparam int ST_OVF   = 3;

   // Clock cycles per serial bit, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_io_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty flags.
// Also intended for the receive-side IO path.
module byte_fifo
   import uart_tx_io_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_n;
   logic          do_push;
   logic          do_pop;

   // A write into a full FIFO is dropped even if a pop happens the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_n = count;
      case ({do_push, do_pop})
         2'b10:   count_n = count + CW'(1);
         2'b01:   count_n = count - CW'(1);
         default: count_n = count;
      endcase
   end

   // Storage array; no reset needed since reads are gated by empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally at the power-of-two depth; flags are registered.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_n;
         full  <= (count_n == CW'(DEPTH));
         empty <= (count_n == '0);
      end
   end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: IO writes fill a FIFO, the FSM drains it.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more data is queued
module uart_tx_io
   import uart_tx_io_pkg::*;
#(
   parameter int CLK_HZ     = 23_000_000,
   parameter int BAUD       = 128_000,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wdata,
   input  logic       clr_ovf,
   output logic [3:0] status,
   output logic       tx
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);
   localparam int TW  = $clog2(DIV);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TW-1:0] BIT_LAST = TW'(DIV - 1);

   tx_state_t     state_q, state_n;
   logic [TW-1:0] timer_q, timer_n;
   logic [2:0]    bit_q, bit_n;
   logic [7:0]    shreg_q, shreg_n;
   logic          tx_q, tx_n;
   logic          ovf_q;
   logic          pop;
   logic          have_data;
   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (wr_en),
      .pop   (pop),
      .wdata (wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign have_data = (fifo_count != '0);
   assign tx        = tx_q;

   assign status[ST_BUSY]  = (state_q != IDLE);
   assign status[ST_EMPTY] = fifo_empty;
   assign status[ST_FULL]  = fifo_full;
   assign status[ST_OVF]   = ovf_q;

   // Serializer registers; tx comes straight from a flop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_n;
         timer_q <= timer_n;
         bit_q   <= bit_n;
         shreg_q <= shreg_n;
         tx_q    <= tx_n;
      end
   end

   // Next state, bit timer reload and line level; tx_n is the level for the coming bit.
   always_comb begin
      state_n = state_q;
      timer_n = (timer_q == '0) ? '0 : timer_q - TW'(1);
      bit_n   = bit_q;
      shreg_n = shreg_q;
      tx_n    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_n = 1'b1;
            if (have_data) begin
               pop     = 1'b1;
               shreg_n = fifo_rdata;
               tx_n    = 1'b0;
               timer_n = BIT_LAST;
               state_n = START;
            end
         end
         START: begin
            if (timer_q == '0) begin
               state_n = DATA;
               timer_n = BIT_LAST;
               bit_n   = 3'd0;
               tx_n    = shreg_q[0];
               shreg_n = {1'b0, shreg_q[7:1]};
            end
         end
         DATA: begin
            if (timer_q == '0) begin
               timer_n = BIT_LAST;
               if (bit_q == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n   = bit_q + 3'd1;
                  tx_n    = shreg_q[0];
                  shreg_n = {1'b0, shreg_q[7:1]};
               end
            end
         end
         STOP: begin
            if (timer_q == '0) begin
               if (have_data) begin
                  pop     = 1'b1;
                  shreg_n = fifo_rdata;
                  tx_n    = 1'b0;
                  timer_n = BIT_LAST;
                  state_n = START;
               end else begin
                  tx_n    = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Sticky overflow; a dropped write wins over a simultaneous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                      ovf_q <= 1'b0;
      else if (wr_en && fifo_full)    ovf_q <= 1'b1;
      else if (clr_ovf)               ovf_q <= 1'b0;
   end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: per-cycle comparison of tx and status against a
// timing model built from frame start times computed arithmetically.
module tb_uart_tx_io;
   import uart_tx_io_pkg::*;

   localparam int CLK_HZ     = 1000;
   localparam int BAUD       = 100;
   localparam int FIFO_DEPTH = 4;
   localparam int DIV        = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int FRAME      = 10 * DIV;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       clr_ovf = 1'b0;
   logic [3:0] status;
   logic       tx;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // Reference model: one entry per accepted byte (push edge, pop edge, value).
   int         fr_w[$];
   int         fr_p[$];
   logic [7:0] fr_b[$];
   int         last_pop = -1000;
   logic       model_ovf = 1'b0;

   uart_tx_io #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wdata   (wdata),
      .clr_ovf (clr_ovf),
      .status  (status),
      .tx      (tx)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Expected line level after edge e.
   function automatic logic model_tx(int e);
      int bn;
      for (int i = 0; i < fr_p.size(); i++) begin
         if (e >= fr_p[i] && e < fr_p[i] + FRAME) begin
            bn = (e - fr_p[i]) / DIV;
            if (bn == 0) return 1'b0;
            if (bn == 9) return 1'b1;
            return fr_b[i][bn-1];
         end
      end
      return 1'b1;
   endfunction

   // Expected status word after edge e.
   function automatic logic [3:0] model_st(int e);
      int   cnt;
      logic busy;
      cnt  = 0;
      busy = 1'b0;
      for (int i = 0; i < fr_p.size(); i++) begin
         if (fr_w[i] <= e && fr_p[i] > e) cnt++;
         if (e >= fr_p[i] && e < fr_p[i] + FRAME) busy = 1'b1;
      end
      return {model_ovf, (cnt == FIFO_DEPTH), (cnt == 0), busy};
   endfunction

   // Drive one clock of inputs (applied at negedge) and update the model for the edge.
   task automatic cycle(input logic we, input logic [7:0] d, input logic clr);
      int e, cnt, p;
      e   = cyc + 1;
      cnt = 0;
      for (int i = 0; i < fr_p.size(); i++)
         if (fr_w[i] < e && fr_p[i] >= e) cnt++;
      if (clr) model_ovf = 1'b0;
      if (we) begin
         if (cnt == FIFO_DEPTH) begin
            model_ovf = 1'b1;
         end else begin
            p = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
            fr_w.push_back(e);
            fr_p.push_back(p);
            fr_b.push_back(d);
            last_pop = p;
         end
      end
      wr_en   = we;
      wdata   = d;
      clr_ovf = clr;
      @(negedge clock);
   endtask

   task automatic model_clear();
      fr_w.delete();
      fr_p.delete();
      fr_b.delete();
      last_pop  = -1000;
      model_ovf = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || status !== 4'b0010) begin
         errors++;
         $display("FAIL reset_hold: tx=%b status=%b, required tx=1 status=0010", tx, status);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (tx !== 1'b1 || status !== 4'b0010) begin
         errors++;
         $display("FAIL reset_release: tx=%b status=%b, required tx=1 status=0010", tx, status);
      end
   endtask

   task automatic test_single();
      cycle(1'b1, 8'h55, 1'b0);
      checks++;
      if (status[ST_EMPTY] !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_push cyc=%0d: empty=%b tx=%b, required empty=0 tx=1", cyc, status[ST_EMPTY], tx);
      end
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (tx !== 1'b0 || status[ST_EMPTY] !== 1'b1 || status[ST_BUSY] !== 1'b1) begin
         errors++;
         $display("FAIL single_pop cyc=%0d: tx=%b status=%b, required tx=0 empty=1 busy=1", cyc, tx, status);
      end
      repeat (FRAME) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL single_line cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
      checks++;
      if (status !== 4'b0010 || tx !== 1'b1) begin
         errors++;
         $display("FAIL single_done cyc=%0d: tx=%b status=%b, required tx=1 status=0010", cyc, tx, status);
      end
   endtask

   task automatic test_burst();
      logic [7:0] bytes [6];
      bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, bytes[i], 1'b0);
         if (i == 4) begin
            checks++;
            if (status[ST_FULL] !== 1'b1 || status[ST_OVF] !== 1'b0) begin
               errors++;
               $display("FAIL burst_full: status=%b, required full=1 ovf=0", status);
            end
         end
         if (i == 5) begin
            checks++;
            if (status[ST_FULL] !== 1'b1 || status[ST_OVF] !== 1'b1) begin
               errors++;
               $display("FAIL burst_ovf: status=%b, required full=1 ovf=1", status);
            end
         end
      end
      repeat (5 * FRAME + 20) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL burst_line cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
   endtask

   task automatic test_ovf_clear();
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (status[ST_OVF] !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b, required 0", status[ST_OVF]);
      end
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0);
      cycle(1'b1, 8'h99, 1'b1);
      checks++;
      if (status[ST_OVF] !== 1'b1 || status[ST_FULL] !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clr_vs_set: status=%b, required ovf=1 full=1", status);
      end
      repeat (5 * FRAME + 20) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL ovf_line cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
   endtask

   task automatic test_reset_mid();
      int p;
      cycle(1'b1, 8'h0F, 1'b0);
      p = cyc + 1;
      while (cyc < p + 4 * DIV + DIV / 2) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL midrst_line cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || status !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_async: tx=%b status=%b, required tx=1 status=0010", tx, status);
      end
      model_clear();
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (tx !== 1'b1 || status !== 4'b0010) begin
         errors++;
         $display("FAIL midrst_after: tx=%b status=%b, required tx=1 status=0010", tx, status);
      end
      cycle(1'b1, 8'h0F, 1'b0);
      repeat (FRAME + 10) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL midrst_frame cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
   endtask

   task automatic test_refill();
      int p;
      cycle(1'b1, 8'h81, 1'b0);
      p = cyc + 1;
      while (cyc < p + 9 * DIV + DIV / 2 - 1) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL refill_line cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
      cycle(1'b1, 8'h7E, 1'b0);
      while (cyc < p + FRAME) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL refill_stop cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
      checks++;
      if (tx !== 1'b0 || status[ST_BUSY] !== 1'b1) begin
         errors++;
         $display("FAIL refill_start cyc=%0d: tx=%b busy=%b, required tx=0 busy=1", cyc, tx, status[ST_BUSY]);
      end
      repeat (FRAME + 10) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL refill_frame cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
   endtask

   task automatic test_wrap();
      int k;
      k = 0;
      while (k < 10) begin
         for (int j = 0; j < 3 && k < 10; j++) begin
            cycle(1'b1, 8'(k), 1'b0);
            k++;
         end
         repeat (3 * FRAME + 10) begin
            cycle(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
               errors++;
               $display("FAIL wrap_line cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
            end
         end
      end
   endtask

   task automatic test_random();
      repeat (1500) begin
         cycle($urandom_range(0, 29) == 0, 8'($urandom), $urandom_range(0, 99) == 0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL random_line cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
      repeat (6 * FRAME) begin
         cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (tx !== model_tx(cyc) || status !== model_st(cyc)) begin
            errors++;
            $display("FAIL random_drain cyc=%0d: tx=%b status=%b, required tx=%b status=%b", cyc, tx, status, model_tx(cyc), model_st(cyc));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_ovf_clear();
      test_reset_mid();
      test_refill();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
